cuckoo_chime: RTL and testbench



---
 rtl/cuckoo_pkg.sv | 24 ++
 rtl/cuckoo_trig_det.sv | 74 +++++++
 rtl/cuckoo_chime.sv | 136 +++++++++++++
 tb/tb_cuckoo_chime.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cuckoo_pkg.sv
// Shared types for the cuckoo chime: FSM states, strike-count width and the
// 24h-to-12h strike mapping.
package cuckoo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_e;

  localparam int STRIKE_W = 4;

  // A 12-hour face strikes 12 at midnight/noon, otherwise hour mod 12.
  function automatic logic [STRIKE_W-1:0] hour_to_strikes(input logic [4:0] hour);
    logic [4:0] h12_s;
    h12_s = (hour >= 5'd12) ? (hour - 5'd12) : hour;
    if (h12_s == 5'd0) begin
      return 4'd12;
    end else begin
      return h12_s[STRIKE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/cuckoo_trig_det.sv
// Chime trigger detector: minute-edge detect, quiet window, mute gate.
// Optional half-hour single strike when CUCKOO_HALF_HOUR_EN is defined.
module cuckoo_trig_det
  import cuckoo_pkg::*;
#(
  parameter int QUIET_START = 0,
  parameter int QUIET_END   = 7,
  parameter int COUNT_MODE  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4:0]          hour,
  input  logic [5:0]          min,
  input  logic                i_mute,
  output logic                trig,
  output logic [STRIKE_W-1:0] strikes
);

  logic [5:0] prev_min_r;
  logic       quiet_s;
  logic       top_s;
`ifdef CUCKOO_HALF_HOUR_EN
  logic       half_s;
`endif

  // Previous minute, sampled every clock so time-set jumps are seen too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_min_r <= 6'd0;
    end else begin
      prev_min_r <= min;
    end
  end

  // Quiet window; START > END wraps past midnight, START == END never quiet.
  always_comb begin
    quiet_s = 1'b0;
    if (QUIET_START < QUIET_END) begin
      quiet_s = (int'(hour) >= QUIET_START) && (int'(hour) < QUIET_END);
    end else if (QUIET_START > QUIET_END) begin
      quiet_s = (int'(hour) >= QUIET_START) || (int'(hour) < QUIET_END);
    end else begin
      quiet_s = 1'b0;
    end
  end

  // Minute edge detect and strike-count selection.
  always_comb begin
    top_s   = (min == 6'd0) && (prev_min_r != 6'd0);
`ifdef CUCKOO_HALF_HOUR_EN
    half_s  = (min == 6'd30) && (prev_min_r != 6'd30);
`endif
    trig    = 1'b0;
    strikes = {STRIKE_W{1'b0}};
    if (quiet_s || i_mute) begin
      trig    = 1'b0;
      strikes = {STRIKE_W{1'b0}};
    end else if (top_s) begin
      trig    = 1'b1;
      strikes = (COUNT_MODE != 0) ? hour_to_strikes(hour) : 4'd1;
    end
`ifdef CUCKOO_HALF_HOUR_EN
    else if (half_s) begin
      trig    = 1'b1;
      strikes = 4'd1;
    end
`endif
    else begin
      trig    = 1'b0;
      strikes = {STRIKE_W{1'b0}};
    end
  end

endmodule

// File: rtl/cuckoo_chime.sv
// Cuckoo chime sequencer: emits a tick-timed pulse train at the top of the hour.
// Half-hour single strike is enabled by defining CUCKOO_HALF_HOUR_EN.
module cuckoo_chime
  import cuckoo_pkg::*;
#(
  parameter int ON_TICKS    = 5,
  parameter int OFF_TICKS   = 5,
  parameter int QUIET_START = 0,
  parameter int QUIET_END   = 7,
  parameter int COUNT_MODE  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_tick,
  input  logic [4:0] hour,
  input  logic [5:0] min,
  input  logic       i_mute,
  output logic       o_cuckoo,
  output logic       o_busy,
  output logic       o_done
);

  localparam int MAX_TICKS = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int CNT_W     = $clog2(MAX_TICKS + 1);
  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_TICKS - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_TICKS - 1);

  state_e                state_r, state_s;
  logic [CNT_W-1:0]      cnt_r, cnt_s;
  logic [STRIKE_W-1:0]   rem_r, rem_s;
  logic                  cuckoo_r, busy_r, done_r, done_s;
  logic                  trig_s;
  logic [STRIKE_W-1:0]   strikes_s;

  cuckoo_trig_det #(
    .QUIET_START (QUIET_START),
    .QUIET_END   (QUIET_END),
    .COUNT_MODE  (COUNT_MODE)
  ) u_trig_det (
    .clk     (clk),
    .rst_n   (rst_n),
    .hour    (hour),
    .min     (min),
    .i_mute  (i_mute),
    .trig    (trig_s),
    .strikes (strikes_s)
  );

  // Next-state logic; the tick counter restarts on every phase entry.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    rem_s   = rem_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (trig_s) begin
          state_s = ON;
          cnt_s   = {CNT_W{1'b0}};
          rem_s   = strikes_s;
        end else begin
          state_s = IDLE;
        end
      end
      ON: begin
        if (i_mute) begin
          state_s = IDLE;
          cnt_s   = {CNT_W{1'b0}};
          rem_s   = {STRIKE_W{1'b0}};
        end else if (i_tick) begin
          if (cnt_r == ON_LAST) begin
            cnt_s = {CNT_W{1'b0}};
            // Last strike leaves straight to IDLE, no trailing gap.
            if (rem_r <= 4'd1) begin
              state_s = IDLE;
              rem_s   = {STRIKE_W{1'b0}};
              done_s  = 1'b1;
            end else begin
              state_s = OFF;
              rem_s   = rem_r - 4'd1;
            end
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end else begin
          state_s = ON;
        end
      end
      OFF: begin
        if (i_mute) begin
          state_s = IDLE;
          cnt_s   = {CNT_W{1'b0}};
          rem_s   = {STRIKE_W{1'b0}};
        end else if (i_tick) begin
          if (cnt_r == OFF_LAST) begin
            state_s = ON;
            cnt_s   = {CNT_W{1'b0}};
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end else begin
          state_s = OFF;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {CNT_W{1'b0}};
        rem_s   = {STRIKE_W{1'b0}};
      end
    endcase
  end

  // State, counters and registered outputs derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      rem_r    <= {STRIKE_W{1'b0}};
      cuckoo_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      rem_r    <= rem_s;
      cuckoo_r <= (state_s == ON);
      busy_r   <= (state_s != IDLE);
      done_r   <= done_s;
    end
  end

  assign o_cuckoo = cuckoo_r;
  assign o_busy   = busy_r;
  assign o_done   = done_r;

endmodule

// File: tb/tb_cuckoo_chime.sv
// Self-checking bench for cuckoo_chime: three configurations, scoreboarded
// sequence records (pulse count, busy length, done) compared per scenario.
module tb_cuckoo_chime;

  typedef struct {
    int id;
    int pulses;
    int busy_len;
    bit done;
    int bad;
  } rec_t;

  rec_t exp_q[$];
  rec_t obs_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic [4:0] hour_v [3];
  logic [5:0] min_v  [3];
  logic [2:0] mute_v;
  logic [2:0] cuckoo, busy, done;

  always #5 clk = ~clk;

  // 0: strike count, quiet 22..6 (wraps); 1: single pulse, quiet 0..6; 2: strike count, never quiet
  cuckoo_chime #(.ON_TICKS(2), .OFF_TICKS(2), .QUIET_START(22), .QUIET_END(7), .COUNT_MODE(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .i_tick(tick), .hour(hour_v[0]), .min(min_v[0]), .i_mute(mute_v[0]),
    .o_cuckoo(cuckoo[0]), .o_busy(busy[0]), .o_done(done[0]));
  cuckoo_chime #(.ON_TICKS(2), .OFF_TICKS(2), .QUIET_START(0), .QUIET_END(7), .COUNT_MODE(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_tick(tick), .hour(hour_v[1]), .min(min_v[1]), .i_mute(mute_v[1]),
    .o_cuckoo(cuckoo[1]), .o_busy(busy[1]), .o_done(done[1]));
  cuckoo_chime #(.ON_TICKS(2), .OFF_TICKS(2), .QUIET_START(4), .QUIET_END(4), .COUNT_MODE(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .i_tick(tick), .hour(hour_v[2]), .min(min_v[2]), .i_mute(mute_v[2]),
    .o_cuckoo(cuckoo[2]), .o_busy(busy[2]), .o_done(done[2]));

  // Per-instance monitor: builds one record per sequence when busy falls.
  for (genvar g = 0; g < 3; g++) begin : mon
    int   pulses, on_w, off_w, blen, bad, stray;
    bit   pc, pb;
    rec_t r;
    initial stray = 0;
    always @(negedge clk) begin
      if (!rst_n) begin
        pulses = 0; on_w = 0; off_w = 0; blen = 0; bad = 0; pc = 1'b0; pb = 1'b0;
      end else begin
        if (cuckoo[g]) begin
          if (!pc) begin
            pulses++;
            if (off_w != 0 && off_w != 2) bad++;
          end
          on_w++;
          off_w = 0;
        end else begin
          if (pc) begin
            if (on_w != 2) bad++;
            on_w = 0;
          end
          if (busy[g]) off_w++;
          else off_w = 0;
        end
        if (busy[g]) blen++;
        if (done[g] && !(pb && !busy[g])) stray++;
        if (pb && !busy[g]) begin
          r.id = g; r.pulses = pulses; r.busy_len = blen; r.done = done[g]; r.bad = bad;
          obs_q.push_back(r);
          pulses = 0; blen = 0; bad = 0;
        end
        pc = cuckoo[g];
        pb = busy[g];
      end
    end
  end

  task automatic rollover(input int id, input logic [4:0] h);
    @(posedge clk); #1;
    hour_v[id] = h;
    min_v[id]  = 6'd59;
    @(posedge clk); #1;
    min_v[id]  = 6'd0;
  endtask

  task automatic wait_obs(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (obs_q.size() > 0) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    tick  = 1'b1;
    mute_v = 3'b000;
    for (int g = 0; g < 3; g++) begin
      hour_v[g] = 5'd15;
      min_v[g]  = 6'd0;
    end
    #2 rst_n = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) begin
      n_checks++;
      if (cuckoo[g] !== 1'b0) begin n_fail++; $display("FAIL reset_cuckoo[%0d]: got %b want 0", g, cuckoo[g]); end
      n_checks++;
      if (busy[g] !== 1'b0) begin n_fail++; $display("FAIL reset_busy[%0d]: got %b want 0", g, busy[g]); end
      n_checks++;
      if (done[g] !== 1'b0) begin n_fail++; $display("FAIL reset_done[%0d]: got %b want 0", g, done[g]); end
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    n_checks++;
    if (obs_q.size() != 0 || busy !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_release_min0: records %0d busy %b want 0 / 000", obs_q.size(), busy);
    end
  endtask

  task automatic test_strike_count();
    int   hrs [9] = '{15, 0, 23, 22, 6, 7, 12, 21, 13};
    int   ns  [9] = '{ 3, 0,  0,  0, 0, 7, 12,  9,  1};
    bit   got;
    rec_t e, o;
    for (int k = 0; k < 9; k++) begin
      if (ns[k] > 0) exp_q.push_back(rec_t'{0, ns[k], 4 * ns[k] - 2, 1'b1, 0});
      rollover(0, 5'(hrs[k]));
      if (ns[k] > 0) begin
        wait_obs(80, got);
        n_checks++;
        if (!got) begin
          n_fail++;
          e = exp_q.pop_front();
          $display("FAIL strike h=%0d: no sequence end within budget", hrs[k]);
        end else begin
          e = exp_q.pop_front();
          o = obs_q.pop_front();
          if (o.id !== e.id || o.pulses !== e.pulses || o.busy_len !== e.busy_len || o.done !== e.done || o.bad !== 0) begin
            n_fail++;
            $display("FAIL strike h=%0d: id/pulses/busy/done/badw got %0d/%0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d/0",
                     hrs[k], o.id, o.pulses, o.busy_len, o.done, o.bad, e.id, e.pulses, e.busy_len, e.done);
          end
        end
      end else begin
        repeat (20) @(negedge clk);
        n_checks++;
        if (obs_q.size() != 0 || busy[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL quiet h=%0d: records %0d busy %b want 0 / 0", hrs[k], obs_q.size(), busy[0]);
        end
      end
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic test_single_pulse();
    int   hrs [5] = '{9, 3, 0, 7, 23};
    int   ns  [5] = '{1, 0, 0, 1, 1};
    bit   got;
    rec_t e, o;
    for (int k = 0; k < 5; k++) begin
      if (ns[k] > 0) exp_q.push_back(rec_t'{1, 1, 2, 1'b1, 0});
      rollover(1, 5'(hrs[k]));
      if (ns[k] > 0) begin
        wait_obs(40, got);
        n_checks++;
        if (!got) begin
          n_fail++;
          e = exp_q.pop_front();
          $display("FAIL single h=%0d: no sequence end within budget", hrs[k]);
        end else begin
          e = exp_q.pop_front();
          o = obs_q.pop_front();
          if (o.id !== e.id || o.pulses !== e.pulses || o.busy_len !== e.busy_len || o.done !== e.done || o.bad !== 0) begin
            n_fail++;
            $display("FAIL single h=%0d: id/pulses/busy/done/badw got %0d/%0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d/0",
                     hrs[k], o.id, o.pulses, o.busy_len, o.done, o.bad, e.id, e.pulses, e.busy_len, e.done);
          end
        end
      end else begin
        repeat (20) @(negedge clk);
        n_checks++;
        if (obs_q.size() != 0 || busy[1] !== 1'b0) begin
          n_fail++;
          $display("FAIL single_quiet h=%0d: records %0d busy %b want 0 / 0", hrs[k], obs_q.size(), busy[1]);
        end
      end
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic test_mute();
    bit   got, prev;
    int   rises;
    rec_t e, o;
    exp_q.push_back(rec_t'{2, 2, 5, 1'b0, 0});
    rollover(2, 5'd5);
    rises = 0;
    prev  = 1'b0;
    for (int i = 0; i < 60 && rises < 2; i++) begin
      @(negedge clk);
      if (cuckoo[2] && !prev) rises++;
      prev = cuckoo[2];
    end
    n_checks++;
    if (rises < 2) begin n_fail++; $display("FAIL mute_second_pulse: saw %0d pulses want 2", rises); end
    mute_v[2] = 1'b1;
    @(negedge clk);
    n_checks++;
    if (cuckoo[2] !== 1'b0 || busy[2] !== 1'b0 || done[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL mute_abort: cuckoo/busy/done got %b/%b/%b want 0/0/0", cuckoo[2], busy[2], done[2]);
    end
    wait_obs(10, got);
    e = exp_q.pop_front();
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL mute_record: no aborted sequence record");
    end else begin
      o = obs_q.pop_front();
      if (o.id !== e.id || o.pulses !== e.pulses || o.busy_len !== e.busy_len || o.done !== e.done) begin
        n_fail++;
        $display("FAIL mute_record: pulses/busy/done got %0d/%0d/%0d want %0d/%0d/%0d",
                 o.pulses, o.busy_len, o.done, e.pulses, e.busy_len, e.done);
      end
    end
    rollover(2, 5'd5);
    repeat (20) @(negedge clk);
    n_checks++;
    if (obs_q.size() != 0 || busy[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL mute_blocks_trigger: records %0d busy %b want 0 / 0", obs_q.size(), busy[2]);
    end
    mute_v[2] = 1'b0;
    repeat (30) @(negedge clk);
    n_checks++;
    if (obs_q.size() != 0 || busy[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL mute_release_no_restart: records %0d busy %b want 0 / 0", obs_q.size(), busy[2]);
    end
  endtask

  task automatic test_back_to_back();
    bit   got;
    rec_t e, o;
    exp_q.push_back(rec_t'{2, 3, 10, 1'b1, 0});
    rollover(2, 5'd3);
    repeat (3) @(posedge clk);
    #1 min_v[2] = 6'd17;
    @(posedge clk);
    #1 min_v[2] = 6'd0;
    wait_obs(60, got);
    e = exp_q.pop_front();
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL busy_drop: no sequence end within budget");
    end else begin
      o = obs_q.pop_front();
      if (o.pulses !== e.pulses || o.busy_len !== e.busy_len || o.done !== e.done || o.bad !== 0) begin
        n_fail++;
        $display("FAIL busy_drop: pulses/busy/done/badw got %0d/%0d/%0d/%0d want %0d/%0d/%0d/0",
                 o.pulses, o.busy_len, o.done, o.bad, e.pulses, e.busy_len, e.done);
      end
    end
    repeat (20) @(negedge clk);
    n_checks++;
    if (obs_q.size() != 0 || busy[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_drop_no_queue: records %0d busy %b want 0 / 0", obs_q.size(), busy[2]);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    rollover(2, 5'd2);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (cuckoo[2]) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL reset_mid_start: cuckoo never rose"); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (cuckoo[2] !== 1'b0 || busy[2] !== 1'b0 || done[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_async: cuckoo/busy/done got %b/%b/%b want 0/0/0", cuckoo[2], busy[2], done[2]);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    n_checks++;
    if (obs_q.size() != 0 || busy !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_mid_release: records %0d busy %b want 0 / 000", obs_q.size(), busy);
    end
  endtask

  task automatic test_half_hour();
    bit   got;
    rec_t e, o;
`ifdef CUCKOO_HALF_HOUR_EN
    exp_q.push_back(rec_t'{2, 1, 2, 1'b1, 0});
`endif
    @(posedge clk); #1;
    hour_v[2] = 5'd10;
    min_v[2]  = 6'd29;
    @(posedge clk); #1;
    min_v[2]  = 6'd30;
`ifdef CUCKOO_HALF_HOUR_EN
    wait_obs(40, got);
    e = exp_q.pop_front();
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL half_hour: no single pulse within budget");
    end else begin
      o = obs_q.pop_front();
      if (o.pulses !== e.pulses || o.busy_len !== e.busy_len || o.done !== e.done) begin
        n_fail++;
        $display("FAIL half_hour: pulses/busy/done got %0d/%0d/%0d want %0d/%0d/%0d",
                 o.pulses, o.busy_len, o.done, e.pulses, e.busy_len, e.done);
      end
    end
`else
    got = 1'b0;
    e.pulses = 0;
    o.pulses = 0;
    repeat (20) @(negedge clk);
    n_checks++;
    if (obs_q.size() != 0 || busy[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL half_hour_disabled: records %0d busy %b want 0 / 0", obs_q.size(), busy[2]);
    end
`endif
  endtask

  task automatic test_tick_hold();
    bit   got, seen;
    rec_t e, o;
    exp_q.push_back(rec_t'{1, 1, 10, 1'b1, 0});
    rollover(1, 5'd9);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (busy[1]) seen = 1'b1;
    end
    tick = 1'b0;
    repeat (8) @(negedge clk);
    n_checks++;
    if (!seen || cuckoo[1] !== 1'b1 || busy[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL tick_hold: started %b cuckoo/busy got %b/%b want 1/1", seen, cuckoo[1], busy[1]);
    end
    tick = 1'b1;
    wait_obs(20, got);
    e = exp_q.pop_front();
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL tick_resume: no sequence end within budget");
    end else begin
      o = obs_q.pop_front();
      if (o.pulses !== e.pulses || o.busy_len !== e.busy_len || o.done !== e.done) begin
        n_fail++;
        $display("FAIL tick_resume: pulses/busy/done got %0d/%0d/%0d want %0d/%0d/%0d",
                 o.pulses, o.busy_len, o.done, e.pulses, e.busy_len, e.done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_strike_count();
    test_single_pulse();
    test_mute();
    test_back_to_back();
    test_reset_mid();
    test_half_hour();
    test_tick_hold();
    repeat (5) @(negedge clk);
    n_checks++;
    if (mon[0].stray != 0 || mon[1].stray != 0 || mon[2].stray != 0) begin
      n_fail++;
      $display("FAIL stray_done: got %0d/%0d/%0d want 0/0/0", mon[0].stray, mon[1].stray, mon[2].stray);
    end
    n_checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: exp %0d obs %0d want 0/0", exp_q.size(), obs_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule
